// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the ALU.
// Stage registers honour flush > stall > load; forwarding is purely combinational.
module id_ex_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  validD,
  input  logic [WIDTH-1:0]      rd1D,
  input  logic [WIDTH-1:0]      rd2D,
  input  logic [WIDTH-1:0]      immExtD,
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  input  logic [REG_ADDR_W-1:0] rdD,
  input  logic [2:0]            ALUControlD,
  input  logic                  ALUSrcD,
  input  logic                  regWriteD,
  input  logic [WIDTH-1:0]      ALUResultM,
  input  logic [REG_ADDR_W-1:0] rdM,
  input  logic                  regWriteM,
  input  logic                  validM,
  input  logic [WIDTH-1:0]      resultW,
  input  logic [REG_ADDR_W-1:0] rdW,
  input  logic                  regWriteW,
  input  logic                  validW,
  output logic [WIDTH-1:0]      srcA,
  output logic [WIDTH-1:0]      srcB,
  output logic [2:0]            ALUControl,
  output logic [WIDTH-1:0]      writeDataE,
  output logic [REG_ADDR_W-1:0] rdE,
  output logic                  regWriteE,
  output logic                  validE,
  output logic [1:0]            forwardA,
  output logic [1:0]            forwardB
);

  logic [WIDTH-1:0]      rd1_q, rd1_d;
  logic [WIDTH-1:0]      rd2_q, rd2_d;
  logic [WIDTH-1:0]      imm_q, imm_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [2:0]            alu_ctrl_q, alu_ctrl_d;
  logic                  alu_src_q, alu_src_d;
  logic                  reg_write_q, reg_write_d;
  logic                  valid_q, valid_d;

  always_comb begin
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alu_ctrl_d  = alu_ctrl_q;
    alu_src_d   = alu_src_q;
    reg_write_d = reg_write_q;
    valid_d     = valid_q;
    if (flush) begin
      // Bubble: every field cleared so the slot cannot write back.
      rd1_d       = '0;
      rd2_d       = '0;
      imm_d       = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      alu_ctrl_d  = '0;
      alu_src_d   = 1'b0;
      reg_write_d = 1'b0;
      valid_d     = 1'b0;
    end else if (!stall) begin
      rd1_d       = rd1D;
      rd2_d       = rd2D;
      imm_d       = immExtD;
      rs1_d       = rs1D;
      rs2_d       = rs2D;
      rd_d        = rdD;
      alu_ctrl_d  = ALUControlD;
      alu_src_d   = ALUSrcD;
      reg_write_d = regWriteD & validD;
      valid_d     = validD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_ctrl_q  <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      valid_q     <= valid_d;
    end
  end

  logic             mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;
  logic [WIDTH-1:0] fwd_a, fwd_b;

  // x0 never forwards; MEM wins over WB because it carries the newer value.
  always_comb begin
    mem_hit_a = validM & regWriteM & (rdM != '0) & (rdM == rs1_q);
    wb_hit_a  = validW & regWriteW & (rdW != '0) & (rdW == rs1_q);
    mem_hit_b = validM & regWriteM & (rdM != '0) & (rdM == rs2_q);
    wb_hit_b  = validW & regWriteW & (rdW != '0) & (rdW == rs2_q);

    forwardA = 2'b00;
    fwd_a    = rd1_q;
    if (mem_hit_a) begin
      forwardA = 2'b10;
      fwd_a    = ALUResultM;
    end else if (wb_hit_a) begin
      forwardA = 2'b01;
      fwd_a    = resultW;
    end

    forwardB = 2'b00;
    fwd_b    = rd2_q;
    if (mem_hit_b) begin
      forwardB = 2'b10;
      fwd_b    = ALUResultM;
    end else if (wb_hit_b) begin
      forwardB = 2'b01;
      fwd_b    = resultW;
    end
  end

  assign srcA       = fwd_a;
  assign writeDataE = fwd_b;
  assign srcB       = alu_src_q ? imm_q : fwd_b;
  assign ALUControl = alu_ctrl_q;
  assign rdE        = rd_q;
  assign regWriteE  = reg_write_q;
  assign validE     = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues expected outputs, a negedge
// monitor pops each entry and compares it with what the DUT presents.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, validD;
  logic [31:0] rd1D, rd2D, immExtD, ALUResultM, resultW;
  logic [4:0]  rs1D, rs2D, rdD, rdM, rdW;
  logic [2:0]  ALUControlD;
  logic        ALUSrcD, regWriteD, regWriteM, validM, regWriteW, validW;
  logic [31:0] srcA, srcB, writeDataE;
  logic [2:0]  ALUControl;
  logic [4:0]  rdE;
  logic        regWriteE, validE;
  logic [1:0]  forwardA, forwardB;

  id_ex_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .validD(validD),
    .rd1D(rd1D), .rd2D(rd2D), .immExtD(immExtD), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .regWriteD(regWriteD),
    .ALUResultM(ALUResultM), .rdM(rdM), .regWriteM(regWriteM), .validM(validM),
    .resultW(resultW), .rdW(rdW), .regWriteW(regWriteW), .validW(validW),
    .srcA(srcA), .srcB(srcB), .ALUControl(ALUControl), .writeDataE(writeDataE),
    .rdE(rdE), .regWriteE(regWriteE), .validE(validE),
    .forwardA(forwardA), .forwardB(forwardB)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        rw;
    logic        v;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic exp_t mk(logic [31:0] a, logic [31:0] b, logic [2:0] ctrl,
                              logic [31:0] wd, logic [4:0] rd, logic rw, logic v,
                              logic [1:0] fa, logic [1:0] fb);
    exp_t e;
    e.a = a; e.b = b; e.ctrl = ctrl; e.wd = wd; e.rd = rd;
    e.rw = rw; e.v = v; e.fa = fa; e.fb = fb;
    return e;
  endfunction

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t  e;
      exp_t  got;
      string nm;
      e   = sb_q.pop_front();
      nm  = nm_q.pop_front();
      got = mk(srcA, srcB, ALUControl, writeDataE, rdE, regWriteE, validE,
               forwardA, forwardB);
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s: got srcA=%h srcB=%h ctrl=%b wd=%h rdE=%0d rwE=%b vE=%b fA=%b fB=%b | want srcA=%h srcB=%h ctrl=%b wd=%h rdE=%0d rwE=%b vE=%b fA=%b fB=%b",
                 nm, got.a, got.b, got.ctrl, got.wd, got.rd, got.rw, got.v, got.fa, got.fb,
                 e.a, e.b, e.ctrl, e.wd, e.rd, e.rw, e.v, e.fa, e.fb);
      end
    end
  end

  task automatic chk(input exp_t e, input string nm);
    sb_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(logic [31:0] r1, logic [31:0] r2, logic [31:0] imm, logic [4:0] s1,
                       logic [4:0] s2, logic [4:0] d, logic [2:0] ctrl, logic asrc,
                       logic rw, logic v);
    rd1D = r1; rd2D = r2; immExtD = imm; rs1D = s1; rs2D = s2; rdD = d;
    ALUControlD = ctrl; ALUSrcD = asrc; regWriteD = rw; validD = v;
  endtask

  task automatic set_mw(logic [4:0] dm, logic [31:0] resm, logic rwm, logic vm,
                        logic [4:0] dw, logic [31:0] resw, logic rww, logic vw);
    rdM = dm; ALUResultM = resm; regWriteM = rwm; validM = vm;
    rdW = dw; resultW = resw; regWriteW = rww; validW = vw;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_d(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    set_mw(5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk(mk(0, 0, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00), "reset_initial");
    rst_n = 1'b1;

    // Basic load
    set_d(32'd7, 32'd3, 32'h0, 5'd1, 5'd2, 5'd4, 3'b001, 1'b0, 1'b1, 1'b1);
    step();
    chk(mk(7, 3, 3'b001, 3, 4, 1, 1, 2'b00, 2'b00), "basic_load");

    // Asynchronous reset mid-cycle with stage loaded
    set_d(32'd5, 32'd3, 32'h0, 5'd1, 5'd2, 5'd4, 3'b001, 1'b0, 1'b1, 1'b1);
    step();
    chk(mk(5, 3, 3'b001, 3, 4, 1, 1, 2'b00, 2'b00), "preload_srcA5");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    chk(mk(0, 0, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00), "async_reset");
    rst_n = 1'b1;

    // Forwarding priority on rs1=5, rs2=6
    set_d(32'hA, 32'hB, 32'h0, 5'd5, 5'd6, 5'd7, 3'b000, 1'b0, 1'b1, 1'b1);
    step();
    set_mw(5'd5, 32'h11, 1'b1, 1'b1, 5'd5, 32'h22, 1'b1, 1'b1);
    chk(mk(32'h11, 32'hB, 3'b000, 32'hB, 7, 1, 1, 2'b10, 2'b00), "fwd_mem_over_wb");
    regWriteM = 1'b0;
    chk(mk(32'h22, 32'hB, 3'b000, 32'hB, 7, 1, 1, 2'b01, 2'b00), "fwd_wb_only");
    validW = 1'b0;
    chk(mk(32'hA, 32'hB, 3'b000, 32'hB, 7, 1, 1, 2'b00, 2'b00), "fwd_wb_invalid");
    set_mw(5'd5, 32'h11, 1'b1, 1'b0, 5'd6, 32'h22, 1'b1, 1'b1);
    chk(mk(32'hA, 32'h22, 3'b000, 32'h22, 7, 1, 1, 2'b00, 2'b01), "fwd_b_wb_m_invalid");

    // x0 never forwarded
    set_d(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1, 1'b1);
    step();
    set_mw(5'd0, 32'hFF, 1'b1, 1'b1, 5'd0, 32'hEE, 1'b1, 1'b1);
    chk(mk(0, 0, 3'b000, 0, 0, 1, 1, 2'b00, 2'b00), "x0_zero_rf");
    set_d(32'h33, 32'h44, 32'h0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1, 1'b1);
    step();
    chk(mk(32'h33, 32'h44, 3'b000, 32'h44, 0, 1, 1, 2'b00, 2'b00), "x0_rf_value");

    // Immediate select with rs2 still forwarded to writeDataE
    set_mw(5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    set_d(32'h55, 32'h44, 32'hFFFF_FFF0, 5'd3, 5'd9, 5'd8, 3'b010, 1'b1, 1'b1, 1'b1);
    step();
    set_mw(5'd9, 32'h77, 1'b1, 1'b1, 5'd0, 32'h0, 1'b0, 1'b0);
    chk(mk(32'h55, 32'hFFFF_FFF0, 3'b010, 32'h77, 8, 1, 1, 2'b00, 2'b10), "imm_fwdB");

    // Stall for three cycles while D inputs change
    set_mw(5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    set_d(32'h100, 32'h200, 32'h0, 5'd10, 5'd11, 5'd12, 3'b011, 1'b0, 1'b1, 1'b1);
    step();
    chk(mk(32'h100, 32'h200, 3'b011, 32'h200, 12, 1, 1, 2'b00, 2'b00), "pre_stall");
    stall = 1'b1;
    set_d(32'h999, 32'h888, 32'h7, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk(mk(32'h100, 32'h200, 3'b011, 32'h200, 12, 1, 1, 2'b00, 2'b00), "stall_hold");
    end
    set_mw(5'd10, 32'hABC, 1'b1, 1'b1, 5'd0, 32'h0, 1'b0, 1'b0);
    chk(mk(32'hABC, 32'h200, 3'b011, 32'h200, 12, 1, 1, 2'b10, 2'b00), "stall_late_fwd");

    // Flush wins over stall
    set_mw(5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    chk(mk(0, 0, 3'b000, 0, 0, 0, 0, 2'b00, 2'b00), "flush_over_stall");

    // Invalid slot gates regWrite
    flush = 1'b0;
    stall = 1'b0;
    set_d(32'h12, 32'h34, 32'h0, 5'd1, 5'd2, 5'd5, 3'b001, 1'b0, 1'b1, 1'b0);
    step();
    chk(mk(32'h12, 32'h34, 3'b001, 32'h34, 5, 0, 0, 2'b00, 2'b00), "invalid_gating");

    // SLT op passes through
    set_d(32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd6, 3'b100, 1'b0, 1'b0, 1'b1);
    step();
    chk(mk(32'h1, 32'h2, 3'b100, 32'h2, 6, 0, 1, 2'b00, 2'b00), "slt_no_write");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, want completion before 100000");
    $fatal(1, "timeout");
  end

endmodule
